// File: rtl/mp_add_seq.sv
// Multi-word add sequencer: streams operand words through an external adder one word
// per pass, chaining the carry between words and handing each result word downstream.
module mp_add_seq #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned MAXW   = 4,
  parameter int unsigned SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       nwords,
  input  logic             cin,
  input  logic [WIDTH-1:0] a_data,
  input  logic [WIDTH-1:0] b_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  output logic             add_cin,
  input  logic [WIDTH-1:0] add_sum,
  input  logic             add_cout,
  output logic [WIDTH-1:0] sum_data,
  output logic             sum_valid,
  output logic             sum_last,
  input  logic             sum_ready,
  output logic             cout,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int unsigned IdxW       = (MAXW > 1) ? $clog2(MAXW) : 1;
  localparam logic [3:0]  SettleLast = 4'(SETTLE - 1);

  typedef enum logic [2:0] {StIdle, StWaitIn, StExec, StHold, StDone} state_e;

  state_e           state_q, state_d;
  logic [2:0]       nwords_q, nwords_d;
  logic [IdxW-1:0]  idx_q, idx_d;
  logic [3:0]       settle_q, settle_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             err_q, err_d;
  logic             add_cin_q, add_cin_d;
  logic [WIDTH-1:0] add_a_q, add_a_d;
  logic [WIDTH-1:0] add_b_q, add_b_d;
  logic [WIDTH-1:0] sum_q, sum_d;

  logic nwords_ok;
  logic is_last;

  assign nwords_ok = (nwords != 3'd0) && (32'(nwords) <= MAXW);
  // idx_q is constant in HOLD, so sum_last stays stable while stalled
  assign is_last   = (3'(idx_q) == (nwords_q - 3'd1));

  always_comb begin
    state_d   = state_q;
    nwords_d  = nwords_q;
    idx_d     = idx_q;
    settle_d  = settle_q;
    carry_d   = carry_q;
    cout_d    = cout_q;
    err_d     = 1'b0;
    add_cin_d = add_cin_q;
    add_a_d   = add_a_q;
    add_b_d   = add_b_q;
    sum_d     = sum_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          if (nwords_ok) begin
            nwords_d = nwords;
            carry_d  = cin;
            idx_d    = '0;
            cout_d   = 1'b0;
            state_d  = StWaitIn;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StWaitIn: begin
        if (in_valid) begin
          add_a_d   = a_data;
          add_b_d   = b_data;
          add_cin_d = carry_q;
          settle_d  = '0;
          state_d   = StExec;
        end
      end
      StExec: begin
        if (settle_q == SettleLast) begin
          sum_d   = add_sum;
          carry_d = add_cout;
          state_d = StHold;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      StHold: begin
        if (sum_ready) begin
          if (is_last) begin
            cout_d  = carry_q;
            state_d = StDone;
          end else begin
            idx_d   = idx_q + IdxW'(1);
            state_d = StWaitIn;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      nwords_q  <= '0;
      idx_q     <= '0;
      settle_q  <= '0;
      carry_q   <= 1'b0;
      cout_q    <= 1'b0;
      err_q     <= 1'b0;
      add_cin_q <= 1'b0;
      add_a_q   <= '0;
      add_b_q   <= '0;
      sum_q     <= '0;
    end else begin
      state_q   <= state_d;
      nwords_q  <= nwords_d;
      idx_q     <= idx_d;
      settle_q  <= settle_d;
      carry_q   <= carry_d;
      cout_q    <= cout_d;
      err_q     <= err_d;
      add_cin_q <= add_cin_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
      sum_q     <= sum_d;
    end
  end

  assign in_ready  = (state_q == StWaitIn);
  assign sum_valid = (state_q == StHold);
  assign sum_last  = sum_valid && is_last;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign err       = err_q;
  assign cout      = cout_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign add_cin   = add_cin_q;
  assign sum_data  = sum_q;

endmodule

// File: tb/tb_mp_add_seq.sv
// Directed bench for mp_add_seq: drives hand-built multi-word additions through a
// behavioural 16-bit adder and checks every handshake cycle against fixed expectations.
module tb_mp_add_seq;

  localparam int unsigned WIDTH  = 16;
  localparam int unsigned MAXW   = 4;
  localparam int unsigned SETTLE = 2;

  logic             clk = 1'b0;
  logic             rst_n, start, cin, in_valid, sum_ready;
  logic [2:0]       nwords;
  logic [WIDTH-1:0] a_data, b_data;
  logic             in_ready, add_cin, add_cout, sum_valid, sum_last, cout, busy, done, err;
  logic [WIDTH-1:0] add_a, add_b, add_sum, sum_data;

  int passed = 0;
  int total  = 0;

  logic [15:0] av[4];
  logic [15:0] bv[4];
  logic [15:0] ev[4];

  always #5 clk = ~clk;

  // External adder model
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + 17'(add_cin);

  mp_add_seq #(
    .WIDTH (WIDTH),
    .MAXW  (MAXW),
    .SETTLE(SETTLE)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .nwords   (nwords),
    .cin      (cin),
    .a_data   (a_data),
    .b_data   (b_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .add_a    (add_a),
    .add_b    (add_b),
    .add_cin  (add_cin),
    .add_sum  (add_sum),
    .add_cout (add_cout),
    .sum_data (sum_data),
    .sum_valid(sum_valid),
    .sum_last (sum_last),
    .sum_ready(sum_ready),
    .cout     (cout),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_add_a"}, 32'(add_a), 32'h0);
    chk({tag, "_add_b"}, 32'(add_b), 32'h0);
    chk({tag, "_sum_data"}, 32'(sum_data), 32'h0);
    chk({tag, "_add_cin"}, 32'(add_cin), 32'h0);
    chk({tag, "_cout"}, 32'(cout), 32'h0);
    chk({tag, "_sum_valid"}, 32'(sum_valid), 32'h0);
    chk({tag, "_sum_last"}, 32'(sum_last), 32'h0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_done"}, 32'(done), 32'h0);
    chk({tag, "_err"}, 32'(err), 32'h0);
  endtask

  // One operation with in_valid/sum_ready asserted on the exact cycles they are needed.
  // stall: cycles sum_ready is held low on word 0; abort_at: word whose EXEC gets a reset.
  task automatic run_op(input int n, input logic ci, input logic ecout, input int stall,
                        input int abort_at);
    logic        c;
    logic [16:0] t;
    nwords = 3'(n);
    cin    = ci;
    start  = 1'b1;
    step();
    start  = 1'b0;
    chk("busy_after_start", 32'(busy), 32'h1);
    chk("cout_cleared", 32'(cout), 32'h0);
    c = ci;
    for (int k = 0; k < n; k++) begin
      a_data   = av[k];
      b_data   = bv[k];
      in_valid = 1'b1;
      chk("in_ready_wait", 32'(in_ready), 32'h1);
      step();
      in_valid = 1'b0;
      chk("add_a", 32'(add_a), 32'(av[k]));
      chk("add_b", 32'(add_b), 32'(bv[k]));
      chk("add_cin_chain", 32'(add_cin), 32'(c));
      chk("in_ready_exec", 32'(in_ready), 32'h0);
      t = {1'b0, av[k]} + {1'b0, bv[k]} + 17'(c);
      c = t[16];
      if (k == abort_at) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_reset_state("abort");
        return;
      end
      repeat (SETTLE) step();
      chk("sum_valid", 32'(sum_valid), 32'h1);
      chk("sum_data", 32'(sum_data), 32'(ev[k]));
      chk("sum_last", 32'(sum_last), 32'(k == n - 1));
      if (stall > 0 && k == 0) begin
        // Offer a bogus operand and an illegal start while stalled; both must be ignored
        in_valid = 1'b1;
        a_data   = 16'hDEAD;
        start    = 1'b1;
        nwords   = 3'd0;
        repeat (stall) begin
          step();
          chk("stall_sum_valid", 32'(sum_valid), 32'h1);
          chk("stall_sum_data", 32'(sum_data), 32'(ev[k]));
          chk("stall_sum_last", 32'(sum_last), 32'(k == n - 1));
          chk("stall_in_ready", 32'(in_ready), 32'h0);
          chk("stall_err", 32'(err), 32'h0);
        end
        in_valid = 1'b0;
        start    = 1'b0;
        nwords   = 3'(n);
      end
      sum_ready = 1'b1;
      step();
      sum_ready = 1'b0;
    end
    chk("done_pulse", 32'(done), 32'h1);
    chk("busy_done", 32'(busy), 32'h1);
    chk("cout_done", 32'(cout), 32'(ecout));
    step();
    chk("done_clear", 32'(done), 32'h0);
    chk("busy_idle", 32'(busy), 32'h0);
    chk("cout_held", 32'(cout), 32'(ecout));
  endtask

  task automatic bad_start(input logic [2:0] nw);
    nwords = nw;
    start  = 1'b1;
    step();
    start  = 1'b0;
    chk("err_pulse", 32'(err), 32'h1);
    chk("err_busy", 32'(busy), 32'h0);
    step();
    chk("err_clear", 32'(err), 32'h0);
    chk("err_busy_after", 32'(busy), 32'h0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    nwords    = 3'd0;
    cin       = 1'b0;
    a_data    = '0;
    b_data    = '0;
    in_valid  = 1'b0;
    sum_ready = 1'b0;
    step();
    step();
    chk_reset_state("reset");
    rst_n = 1'b1;
    step();

    // 0xFFFF + 0x0001 -> 0x0000 carry out
    av[0] = 16'hFFFF; bv[0] = 16'h0001; ev[0] = 16'h0000;
    run_op(1, 1'b0, 1'b1, 0, -1);

    // Carry ripples through four words
    av = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    bv = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
    ev = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    run_op(4, 1'b0, 1'b1, 0, -1);

    // cin=1: 0x1234+0x0001+1 = 0x1236; 0x8000+0x8000 = 0x0000 carry 1
    av = '{16'h1234, 16'h8000, 16'h0000, 16'h0000};
    bv = '{16'h0001, 16'h8000, 16'h0000, 16'h0000};
    ev = '{16'h1236, 16'h0000, 16'h0000, 16'h0000};
    run_op(2, 1'b1, 1'b1, 0, -1);

    bad_start(3'd0);
    bad_start(3'd5);

    // Stall word 0 for 5 cycles with spurious in_valid and start
    av = '{16'h0001, 16'h0002, 16'h0003, 16'h0000};
    bv = '{16'h0010, 16'h0020, 16'h0030, 16'h0000};
    ev = '{16'h0011, 16'h0022, 16'h0033, 16'h0000};
    run_op(3, 1'b0, 1'b0, 5, -1);

    // Reset during EXEC of word 2 of 3
    av = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000};
    bv = '{16'h0001, 16'h0000, 16'h0000, 16'h0000};
    ev = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    run_op(3, 1'b0, 1'b0, 0, 2);

    // Start on the first cycle after reset release: 0x7FFF+0x8000+1 -> 0x0000 carry 1
    av[0] = 16'h7FFF; bv[0] = 16'h8000; ev[0] = 16'h0000;
    run_op(1, 1'b1, 1'b1, 0, -1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mp_add_seq.md
MP_ADD_SEQ -- requirements
Module: mp_add_seq

Multi-word add sequencer: runs multi-precision additions through one external 16-bit carry-lookahead adder, one word per pass, carry chained between words.

Interface
REQ-001 Parameter WIDTH, default 16, datapath word width (matches external adder).
REQ-002 Parameter MAXW, default 4, maximum words per operation.
REQ-003 Parameter SETTLE, default 1, EXEC cycles allowed for adder settling (range 1..15).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  begin operation (sampled in IDLE only).
REQ-007 nwords  in  3  word count for this operation, legal 1..MAXW.
REQ-008 cin  in  1  carry into word 0, sampled with start.
REQ-009 a_data, b_data  in  WIDTH  operand words, LSW first.
REQ-010 in_valid  in  1 / in_ready  out  1  operand handshake.
REQ-011 add_a, add_b  out  WIDTH; add_cin  out  1  registered drive to external adder.
REQ-012 add_sum  in  WIDTH; add_cout  in  1  external adder result.
REQ-013 sum_data  out  WIDTH; sum_valid  out  1; sum_last  out  1; sum_ready  in  1  result handshake.
REQ-014 cout  out  1  final carry-out of last completed operation.
REQ-015 busy  out  1; done  out  1; err  out  1  status.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_IN, EXEC, HOLD, DONE.
REQ-017 IDLE: busy=0, in_ready=0; start with nwords in 1..MAXW -> latch nwords, carry_reg<=cin, word_idx<=0, cout<=0, go WAIT_IN.
REQ-018 IDLE: start with nwords=0 or >MAXW -> err=1 for exactly one cycle, stay IDLE.
REQ-019 start outside IDLE SHALL be ignored (no err, no state change).
REQ-020 WAIT_IN: in_ready=1; on in_valid&in_ready -> add_a<=a_data, add_b<=b_data, add_cin<=carry_reg, settle counter<=0, go EXEC.
REQ-021 EXEC: in_ready=0; stay exactly SETTLE cycles; on final EXEC cycle capture sum_data<=add_sum, carry_reg<=add_cout, go HOLD.
REQ-022 HOLD: sum_valid=1, sum_last=(word_idx==nwords-1); sum_data, sum_last SHALL stay stable until sum_ready.
REQ-023 HOLD with sum_ready: not last -> word_idx+1, WAIT_IN; last -> cout<=carry_reg, go DONE.
REQ-024 DONE: done=1 for one cycle, busy=1, then IDLE; cout held until next accepted start.
REQ-025 busy=1 in every state except IDLE.
REQ-026 Latency per word with in_valid and sum_ready held high: 1 (accept) + SETTLE + 1 (HOLD) cycles; no overlap between words.
REQ-027 Carry chain: add_cin of word k SHALL equal add_cout captured for word k-1; word 0 uses cin.
REQ-028 word_idx width ceil(log2(MAXW)); never exceeds nwords-1.
REQ-029 in_valid outside WAIT_IN SHALL have no effect; operand words are never dropped or duplicated.

Reset
REQ-030 rst_n=0 at a clock edge -> state IDLE; add_a, add_b, sum_data=0; add_cin, carry_reg, word_idx, cout, sum_valid, sum_last, in_ready, busy, done, err=0.
REQ-031 Reset mid-operation SHALL abandon the operation without a done pulse; a start in the first cycle after rst_n returns high SHALL be accepted normally.

Verification
REQ-032 nwords=1, cin=0, a=0xFFFF, b=0x0001 -> one result 0x0000, sum_last=1, cout=1, done one cycle.
REQ-033 nwords=4, cin=0, a words 0xFFFF x4, b words 0x0001,0,0,0 -> results 0x0000 x4, add_cin=1 on words 1..3, cout=1.
REQ-034 nwords=2, cin=1, a=0x1234,0x8000, b=0x0001,0x8000 -> results 0x1236, 0x0000, cout=1.
REQ-035 sum_ready low 5 cycles in HOLD -> sum_valid=1 and sum_data constant all 5 cycles, in_ready=0, no extra operand accepted.
REQ-036 start with nwords=0, then nwords=5 -> err pulse each, busy stays 0; start asserted mid-operation -> ignored, results unchanged.
REQ-037 rst_n low one cycle during EXEC of word 2 of 3 -> next cycle all outputs at REQ-030 values, no done; following nwords=1 operation completes correctly.
